fp_normalize: RTL and testbench



---
 rtl/fp_normalize.sv | 153 +++++++++++++++
 tb/tb_fp_normalize.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_normalize.sv
// fp_normalize: post-add mantissa normalizer.
// Takes the raw 9-bit mantissa sum (carry in bit 8, hidden bit in bit 7)
// and the common exponent, then either shifts right once on carry or
// shifts left one bit per cycle until the hidden bit is set. Shifting
// stops early with a flag on zero, exponent overflow or exponent underflow.
module fp_normalize (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] exp_in,
    input  logic [8:0] mant_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] exp_out,
    output logic [7:0] mant_out,
    output logic       zero,
    output logic       ovf,
    output logic       unf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_exp;
    logic [8:0] r_mant;
    logic       r_busy;
    logic       r_done;
    logic [7:0] r_exp_out;
    logic [7:0] r_mant_out;
    logic       r_zero;
    logic       r_ovf;
    logic       r_unf;

    state_t     w_state_nx;
    logic [7:0] w_exp_nx;
    logic [8:0] w_mant_nx;
    logic       w_load_out;
    logic       w_zero_nx;
    logic       w_ovf_nx;
    logic       w_unf_nx;

    // Next-state and working-register update; rules in RUN are tried in priority order.
    always_comb begin
        w_state_nx = r_state;
        w_exp_nx   = r_exp;
        w_mant_nx  = r_mant;
        w_load_out = 1'b0;
        w_zero_nx  = 1'b0;
        w_ovf_nx   = 1'b0;
        w_unf_nx   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nx = S_RUN;
                    w_exp_nx   = exp_in;
                    w_mant_nx  = mant_in;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_mant == 9'd0) begin
                    // Zero result: exponent forced to zero.
                    w_exp_nx   = 8'd0;
                    w_zero_nx  = 1'b1;
                    w_load_out = 1'b1;
                    w_state_nx = S_DONE;
                end else if (r_mant[8] && (r_exp != 8'hFF)) begin
                    // Carry out: one right shift, LSB is dropped.
                    w_mant_nx  = {1'b0, r_mant[8:1]};
                    w_exp_nx   = r_exp + 8'd1;
                    w_load_out = 1'b1;
                    w_state_nx = S_DONE;
                end else if (r_mant[8]) begin
                    // Carry with exponent saturated: overflow, no wrap.
                    w_mant_nx  = 9'd0;
                    w_exp_nx   = 8'hFF;
                    w_ovf_nx   = 1'b1;
                    w_load_out = 1'b1;
                    w_state_nx = S_DONE;
                end else if (r_mant[7]) begin
                    // Already normalized.
                    w_load_out = 1'b1;
                    w_state_nx = S_DONE;
                end else if (r_exp == 8'd0) begin
                    // Cannot shift further: leave as denormal.
                    w_unf_nx   = 1'b1;
                    w_load_out = 1'b1;
                    w_state_nx = S_DONE;
                end else begin
                    // One left shift per cycle until the hidden bit appears.
                    w_mant_nx  = {r_mant[7:0], 1'b0};
                    w_exp_nx   = r_exp - 8'd1;
                    w_state_nx = S_RUN;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // State, working registers and registered outputs; results load only on entry to DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_exp      <= 8'd0;
            r_mant     <= 9'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_exp_out  <= 8'd0;
            r_mant_out <= 8'd0;
            r_zero     <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_exp   <= w_exp_nx;
            r_mant  <= w_mant_nx;
            r_busy  <= (w_state_nx != S_IDLE);
            r_done  <= (w_state_nx == S_DONE);
            if (w_load_out) begin
                r_exp_out  <= w_exp_nx;
                r_mant_out <= w_mant_nx[7:0];
                r_zero     <= w_zero_nx;
                r_ovf      <= w_ovf_nx;
                r_unf      <= w_unf_nx;
            end else begin
                r_exp_out  <= r_exp_out;
                r_mant_out <= r_mant_out;
                r_zero     <= r_zero;
                r_ovf      <= r_ovf;
                r_unf      <= r_unf;
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign exp_out  = r_exp_out;
    assign mant_out = r_mant_out;
    assign zero     = r_zero;
    assign ovf      = r_ovf;
    assign unf      = r_unf;

endmodule

// File: tb/tb_fp_normalize.sv
// Testbench for fp_normalize: directed corner cases plus randomized
// operations, scored against an arithmetic reference model via a queue.
module tb_fp_normalize;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] exp_in;
    logic [8:0] mant_in;
    logic       busy;
    logic       done;
    logic [7:0] exp_out;
    logic [7:0] mant_out;
    logic       zero;
    logic       ovf;
    logic       unf;

    typedef struct {
        logic [7:0] e;
        logic [7:0] m;
        logic       z;
        logic       o;
        logic       u;
        int         k;
        int         s;
    } res_t;

    res_t q[$];
    res_t last;
    res_t mon_x;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    fp_normalize dut (
        .clk(clk), .reset_n(reset_n), .start(start), .exp_in(exp_in), .mant_in(mant_in),
        .busy(busy), .done(done), .exp_out(exp_out), .mant_out(mant_out),
        .zero(zero), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    // Edge counter used to measure latency from the accepting edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: find the leading one and apply the normalization rules arithmetically.
    function automatic res_t model(input logic [7:0] e, input logic [8:0] m);
        res_t r;
        int ei, mi, msb, lz;
        r = '{default: 0};
        ei = int'(e);
        mi = int'(m);
        if (mi == 0) begin
            r.z = 1'b1;
        end else if (mi >= 256) begin
            if (ei == 255) begin
                r.o = 1'b1;
                r.e = 8'hFF;
            end else begin
                r.e = 8'(ei + 1);
                r.m = 8'(mi / 2);
            end
        end else begin
            msb = 0;
            for (int b = 0; b < 8; b++) if (mi >= (1 << b)) msb = b;
            lz = 7 - msb;
            if (lz <= ei) begin
                r.k = lz;
                r.e = 8'(ei - lz);
                r.m = 8'(mi * (1 << lz));
            end else begin
                r.k = ei;
                r.e = 8'd0;
                r.m = 8'(mi * (1 << ei));
                r.u = 1'b1;
            end
        end
        return r;
    endfunction

    // Monitor: every done pulse is matched against the oldest pending expectation.
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                mon_x = q.pop_front();
                chk("exp_out", 32'(exp_out), 32'(mon_x.e));
                chk("mant_out", 32'(mant_out), 32'(mon_x.m));
                chk("flags", {29'd0, zero, ovf, unf}, {29'd0, mon_x.z, mon_x.o, mon_x.u});
                chk("latency", 32'(cyc - mon_x.s + 1), 32'(mon_x.k + 2));
                chk("flags_onehot", 32'(int'(zero) + int'(ovf) + int'(unf) <= 1), 32'd1);
            end
        end
    end

    task automatic run_op(input logic [7:0] e, input logic [8:0] m, input bit glitch);
        res_t r;
        int n;
        @(negedge clk);
        exp_in  = e;
        mant_in = m;
        start   = 1'b1;
        @(posedge clk);
        #1;
        r   = model(e, m);
        r.s = cyc;
        q.push_back(r);
        start = 1'b0;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done) break;
            chk("hold_outputs", {13'd0, exp_out, mant_out, zero, ovf, unf},
                {13'd0, last.e, last.m, last.z, last.o, last.u});
            chk("busy_run", 32'(busy), 32'd1);
            if (glitch) begin
                start   = 1'($urandom_range(0, 1));
                exp_in  = 8'($urandom);
                mant_in = 9'($urandom);
            end
        end
        if (n == 20) chk("done_timeout", 32'd0, 32'd1);
        start = 1'b0;
        last  = r;
        @(negedge clk);
        chk("done_pulse", {30'd0, done, busy}, 32'd0);
        chk("result_held", {13'd0, exp_out, mant_out, zero, ovf, unf},
            {13'd0, r.e, r.m, r.z, r.o, r.u});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e;
        logic [8:0] m;
        reset_n = 1'b0;
        start   = 1'b0;
        exp_in  = 8'd0;
        mant_in = 9'd0;
        last    = '{default: 0};
        repeat (2) @(negedge clk);
        chk("reset_outputs", {11'd0, busy, done, exp_out, mant_out, zero, ovf, unf}, 32'd0);
        reset_n = 1'b1;

        run_op(8'h10, 9'h0C0, 1'b0);
        run_op(8'h10, 9'h181, 1'b0);
        run_op(8'h10, 9'h001, 1'b0);
        run_op(8'h02, 9'h010, 1'b0);
        run_op(8'h10, 9'h000, 1'b0);
        run_op(8'hFF, 9'h100, 1'b1);
        run_op(8'h00, 9'h040, 1'b1);
        run_op(8'h07, 9'h001, 1'b1);

        // Reset during RUN: operation abandoned, no done pulse.
        @(negedge clk);
        exp_in  = 8'h10;
        mant_in = 9'h001;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrun_reset", {11'd0, busy, done, exp_out, mant_out, zero, ovf, unf}, 32'd0);
        @(negedge clk);
        chk("midrun_reset_hold", {30'd0, busy, done}, 32'd0);
        reset_n = 1'b1;
        last = '{default: 0};
        run_op(8'h10, 9'h080, 1'b0);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0: e = 8'($urandom_range(0, 3));
                1: e = 8'($urandom_range(252, 255));
                default: e = 8'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0: m = 9'($urandom_range(0, 511));
                1: m = 9'($urandom_range(0, 511) >> $urandom_range(0, 8));
                2: m = ($urandom_range(0, 1) == 0) ? 9'h000 : 9'h100;
                default: m = 9'($urandom_range(1, 255) >> $urandom_range(0, 7));
            endcase
            run_op(e, m, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
